// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the loopback UART.
//   - uart_state_e : state encoding shared by the TX and RX FSMs
//   - DATA_BITS    : payload bits per frame (8N1)
//   - calc_bit_cyc : clocks per serial bit from clock rate and baud rate
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Integer division: any fractional remainder of the bit period is dropped.
  function automatic int calc_bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with mid-bit sampling.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   i_line   in   serial line (idle high)
//   o_data   out  last correctly framed byte
//   o_done   out  sticky receive-done flag; cleared by the next start edge
`timescale 1ns/1ps
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BIT_CYC = 104
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_line,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_done
);

  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC) + 1;
  localparam int BW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST     = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST    = CW'(HALF_CYC - 1);
  localparam logic [BW-1:0] BIT_IDX_LAST = BW'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_next;
  logic                 r_line_s;   // line sampled into the clock domain
  logic                 r_line_p;   // previous sample, for edge detection
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 w_fall;
  logic                 w_tick;

  assign w_fall = r_line_p & ~r_line_s;
  // START waits half a bit to land mid-bit; later states step a whole bit.
  assign w_tick = (r_state == START) ? (r_cnt == HALF_LAST) : (r_cnt == BIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_next = START;
      START:   if (w_tick) w_next = r_line_s ? IDLE : DATA;
      DATA:    if (w_tick && (r_bit_idx == BIT_IDX_LAST)) w_next = STOP;
      STOP:    if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line_s  <= 1'b1;
      r_line_p  <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_line_s <= i_line;
      r_line_p <= r_line_s;
      if ((r_state == IDLE) || w_tick) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_done    <= 1'b0;
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shreg <= {r_line_s, r_shreg[DATA_BITS-1:1]};
            if (r_bit_idx != BIT_IDX_LAST) r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        STOP: begin
          // A low stop bit is a framing error: outputs are left untouched.
          if (w_tick && r_line_s) begin
            r_data <= r_shreg;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data = r_data;
  assign o_done = r_done;

endmodule

// File: rtl/uart_loopback_top.sv
// uart_loopback_top: 8N1 UART transmitter looped back into a receiver.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   data      in   byte to send, latched on the accepted t_start edge
//   t_start   in   transmit request
//   data_out  out  last correctly received byte
//   r_stop    out  sticky receive-done flag
// Request semantics: t_start has no ready/ack. A 0->1 transition seen while
// the transmitter is IDLE launches exactly one frame; holding it high or
// toggling it while a frame is in flight has no effect.
`timescale 1ns/1ps
module uart_loopback_top
  import uart_pkg::*;
#(
  parameter int clk_rate  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 t_start,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 r_stop
);

  localparam int BIT_CYC = calc_bit_cyc(clk_rate, baud_rate);
  localparam int CW      = $clog2(BIT_CYC) + 1;
  localparam int BW      = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST     = CW'(BIT_CYC - 1);
  localparam logic [BW-1:0] BIT_IDX_LAST = BW'(DATA_BITS - 1);

  uart_state_e          r_tx_state;
  uart_state_e          w_tx_next;
  logic                 r_tstart_d;
  logic [CW-1:0]        r_tx_cnt;
  logic [BW-1:0]        r_tx_bit_idx;
  logic [DATA_BITS-1:0] r_tx_shreg;
  logic                 w_tstart_rise;
  logic                 w_tx_tick;
  logic                 w_line;

  assign w_tstart_rise = t_start & ~r_tstart_d;
  assign w_tx_tick     = (r_tx_cnt == BIT_LAST);

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      IDLE:    if (w_tstart_rise) w_tx_next = START;
      START:   if (w_tx_tick) w_tx_next = DATA;
      DATA:    if (w_tx_tick && (r_tx_bit_idx == BIT_IDX_LAST)) w_tx_next = STOP;
      STOP:    if (w_tx_tick) w_tx_next = IDLE;
      default: w_tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tx_state <= IDLE;
    else      r_tx_state <= w_tx_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tstart_d   <= 1'b0;
      r_tx_cnt     <= '0;
      r_tx_bit_idx <= '0;
      r_tx_shreg   <= '0;
    end else begin
      r_tstart_d <= t_start;
      if ((r_tx_state == IDLE) || w_tx_tick) r_tx_cnt <= '0;
      else                                   r_tx_cnt <= r_tx_cnt + 1'b1;
      case (r_tx_state)
        IDLE: begin
          if (w_tstart_rise) begin
            r_tx_shreg   <= data;
            r_tx_bit_idx <= '0;
          end
        end
        DATA: begin
          if (w_tx_tick) begin
            r_tx_shreg <= r_tx_shreg >> 1;
            if (r_tx_bit_idx != BIT_IDX_LAST) r_tx_bit_idx <= r_tx_bit_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line level is a pure function of TX state, so reset forces it high.
  always_comb begin
    w_line = 1'b1;
    case (r_tx_state)
      START:   w_line = 1'b0;
      DATA:    w_line = r_tx_shreg[0];
      default: w_line = 1'b1;
    endcase
  end

  uart_rx_core #(
    .BIT_CYC(BIT_CYC)
  ) u_rx (
    .clk    (clk),
    .rst    (rst),
    .i_line (w_line),
    .o_data (data_out),
    .o_done (r_stop)
  );

endmodule

// File: tb/tb_uart_loopback_top.sv
`timescale 1ns/1ps
module tb_uart_loopback_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = 8'h00;
  logic       t_start = 1'b0;
  wire  [7:0] data_out;
  wire        r_stop;

  int   total = 0;
  int   bad = 0;
  int   rise_cnt = 0;
  logic stop_prev = 1'b0;

  // 1 MHz clock
  always #500 clk = ~clk;

  uart_loopback_top #(
    .clk_rate  (1000000),
    .baud_rate (9600)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .t_start  (t_start),
    .data_out (data_out),
    .r_stop   (r_stop)
  );

  // Counts r_stop rising edges, observed away from the active edge.
  always @(negedge clk) begin
    if (r_stop === 1'b1 && stop_prev !== 1'b1) rise_cnt = rise_cnt + 1;
    stop_prev = r_stop;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    data    = b;
    t_start = 1'b1;
    cycles(2);
    t_start = 1'b0;
  endtask

  task automatic wait_stop(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(negedge clk);
      n = n + 1;
      if (r_stop === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit line_bad;
    bit out_bad;
    rst = 1'b0;
    #1000;
    @(negedge clk);
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    total++;
    if (r_stop !== 1'b0) begin bad++; $display("FAIL reset_r_stop: got %b want 0", r_stop); end
    rst = 1'b1;
    line_bad = 1'b0;
    out_bad  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dut.w_line !== 1'b1) line_bad = 1'b1;
      if (data_out !== 8'h00 || r_stop !== 1'b0) out_bad = 1'b1;
    end
    total++;
    if (line_bad) begin bad++; $display("FAIL idle_line: got low want high"); end
    total++;
    if (out_bad) begin bad++; $display("FAIL idle_outputs: got %h/%b want 00/0", data_out, r_stop); end
  endtask

  task automatic test_single_held();
    int n;
    bit ok;
    int base;
    @(negedge clk);
    base    = rise_cnt;
    data    = 8'hA5;
    t_start = 1'b1;
    wait_stop(1100, n, ok);
    total++;
    if (!ok || n < 988 || n > 994) begin
      bad++; $display("FAIL held_latency: got %0d cycles (ok=%b) want 988..994", n, ok);
    end
    total++;
    if (data_out !== 8'hA5) begin bad++; $display("FAIL held_data: got %h want a5", data_out); end
    cycles(1800 - n);
    total++;
    if (r_stop !== 1'b1) begin bad++; $display("FAIL held_sticky: got %b want 1", r_stop); end
    total++;
    if (rise_cnt - base != 1) begin bad++; $display("FAIL held_one_frame: got %0d rises want 1", rise_cnt - base); end
    t_start = 1'b0;
    cycles(5);
  endtask

  task automatic test_sequence();
    logic [7:0] vec [3];
    int n;
    bit ok;
    vec[0] = 8'h00;
    vec[1] = 8'hFF;
    vec[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      pulse(vec[i]);
      cycles(10);
      total++;
      if (r_stop !== 1'b0) begin bad++; $display("FAIL seq_drop_%0d: got %b want 0", i, r_stop); end
      wait_stop(1100, n, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL seq_rise_%0d: got timeout want r_stop=1", i); end
      total++;
      if (data_out !== vec[i]) begin bad++; $display("FAIL seq_data_%0d: got %h want %h", i, data_out, vec[i]); end
      cycles(60);
    end
  endtask

  task automatic test_data_latch();
    int n;
    bit ok;
    pulse(8'h5A);
    cycles(300);
    data = 8'h11;
    total++;
    if (r_stop !== 1'b0) begin bad++; $display("FAIL latch_drop: got %b want 0", r_stop); end
    wait_stop(1100, n, ok);
    total++;
    if (!ok || data_out !== 8'h5A) begin
      bad++; $display("FAIL latch_data: got %h (ok=%b) want 5a", data_out, ok);
    end
    cycles(60);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    pulse(8'h77);
    cycles(500);
    rst = 1'b0;
    cycles(3);
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", data_out); end
    total++;
    if (r_stop !== 1'b0) begin bad++; $display("FAIL midrst_stop: got %b want 0", r_stop); end
    total++;
    if (dut.w_line !== 1'b1) begin bad++; $display("FAIL midrst_line: got %b want 1", dut.w_line); end
    rst  = 1'b1;
    base = rise_cnt;
    cycles(1200);
    total++;
    if (rise_cnt - base != 0) begin bad++; $display("FAIL midrst_no_done: got %0d rises want 0", rise_cnt - base); end
    total++;
    if (data_out !== 8'h00 || r_stop !== 1'b0) begin
      bad++; $display("FAIL midrst_after: got %h/%b want 00/0", data_out, r_stop);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    bit ok;
    int base;
    base = rise_cnt;
    pulse(8'hC3);
    cycles(200);
    pulse(8'h18);
    wait_stop(1100, n, ok);
    total++;
    if (!ok || data_out !== 8'hC3) begin
      bad++; $display("FAIL busy_first: got %h (ok=%b) want c3", data_out, ok);
    end
    cycles(1300);
    total++;
    if (rise_cnt - base != 1) begin bad++; $display("FAIL busy_one_rise: got %0d want 1", rise_cnt - base); end
    total++;
    if (data_out !== 8'hC3 || r_stop !== 1'b1) begin
      bad++; $display("FAIL busy_hold: got %h/%b want c3/1", data_out, r_stop);
    end
  endtask

  initial begin
    test_reset();
    test_single_held();
    test_sequence();
    test_data_latch();
    test_reset_mid_frame();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_loopback_top.md
Name: uart_loopback_top

Overview:
Self-contained 8N1 UART with an internal loopback.
- A transmitter serialises the byte on `data` when `t_start` rises.
- The serial line feeds a receiver inside the same block.
- The receiver recovers the byte on `data_out` and raises `r_stop` when a valid frame has been received.
- Used as a protocol demo/self-test block; the serial line is not brought out.

Parameters:
- clk_rate, 1000000, system clock frequency in Hz.
- baud_rate, 9600, serial bit rate in baud.
- (derived localparam) BIT_CYC = clk_rate / baud_rate, integer division; 104 at defaults.
- (derived localparam) HALF_CYC = BIT_CYC / 2; 52 at defaults.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- data  input  8  byte to transmit; sampled on the start trigger.
- t_start  input  1  transmit request; rising edge launches one frame.
- data_out  output  8  last correctly received byte.
- r_stop  output  1  receive-done flag, level (sticky).

Behaviour:
- Reset (`rst`=0, async) forces every state machine to IDLE, counters to 0, serial line to 1 (idle).
- Reset values: `data_out`=8'h00, `r_stop`=0. Reset mid-frame aborts the frame with no output update.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts BIT_CYC clocks.

TX FSM, states IDLE, START, DATA, STOP:
- A rising edge of `t_start` (registered compare) seen in IDLE latches `data` into a shift register and enters START on the next clock.
- Level-high `t_start` does not retrigger; a second frame needs `t_start` to go low then high again.
- Rising edges while busy are ignored.
- Bit counter 0..7 in DATA. After STOP completes (BIT_CYC clocks), return to IDLE with the line at 1.

RX FSM, states IDLE, START, DATA, STOP:
- IDLE: a falling edge (1->0) of the line enters START and clears `r_stop` to 0.
- START: wait HALF_CYC clocks, resample the line.
  - 0 -> DATA.
  - 1 -> glitch, back to IDLE; `r_stop` stays 0.
- DATA: sample every BIT_CYC clocks at mid-bit, shifting LSB first, 8 samples.
- STOP: sample after a further BIT_CYC clocks.
  - 1 -> copy the shift register to `data_out`, set `r_stop`=1, go to IDLE.
  - 0 -> framing error: `data_out` unchanged, `r_stop` stays 0, go to IDLE.

Output holding rules:
- `r_stop` holds 1 until the next start edge or reset.
- `data_out` holds its value until the next valid frame.

Timing and arithmetic:
- Latency from the `t_start` rising edge to `r_stop` rising is about HALF_CYC + 9·BIT_CYC + 3 clocks, i.e. ≈991 clocks (±3) at defaults.
- Counters are sized with $clog2(BIT_CYC)+1 bits and use no overflow or wraparound beyond the terminal count.

Decomposition:
- Shared package uart_pkg holds:
  - the TX/RX state enum (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - a function computing BIT_CYC from clk_rate and baud_rate.
- One natural sub-module: uart_rx_core (receiver FSM, mid-bit sampler, `data_out`/`r_stop` registers).
- The transmitter FSM and loopback wire live in uart_loopback_top.

Test Plan:
1. Reset for 1 µs, release, then `data`=8'hA5 and `t_start`=1 held for 1.8 ms. Required: `data_out`=8'hA5 and `r_stop`=1 about 991 clocks after the edge, with exactly one frame sent.
2. After reset with no stimulus: `data_out`=8'h00, `r_stop`=0, line idle high indefinitely.
3. Pulse `t_start` with 8'h00, then 8'hFF, then 8'h3C, each after the prior `r_stop`. Required: `data_out` follows each value in turn, and `r_stop` drops at each new start bit and re-rises.
4. Pulse `t_start` with 8'h5A, then change `data` to 8'h11 mid-frame. Required: received byte is 8'h5A, since `data` is latched at the edge.
5. Assert `rst`=0 mid-frame (e.g. 500 clocks after start) and release. Required: outputs are 8'h00/0, and no `r_stop` from the aborted frame.
6. Send a second `t_start` edge while TX is busy. Required: it is ignored, and exactly one `r_stop` rise with the first byte.
